// File: rtl/execute_vector_stage.sv
// Execute stage: one scalar op or a 64-bit vector op spread over 1..8 lane-groups per cycle.
// Optional macro VECTOR_SATURATE_EN makes vector add/sub clamp per lane instead of wrapping.

module alu_lane #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_r,
  output logic         o_c,
  output logic         o_v
);
  logic [W:0] w_sum, w_dif;
  logic [2:0] w_sh;

  always_comb begin
    w_sum = {1'b0, i_a} + {1'b0, i_b};
    w_dif = {1'b0, i_a} - {1'b0, i_b};
    w_sh  = i_b[2:0];
    o_r   = i_a;
    o_c   = 1'b0;
    o_v   = 1'b0;
    case (i_op)
      3'd0: begin
        o_r = w_sum[W-1:0];
        o_c = w_sum[W];
        o_v = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
        if (SAT && w_sum[W]) o_r = '1;
      end
      3'd1: begin
        o_r = w_dif[W-1:0];
        o_c = ~w_dif[W];
        o_v = (i_a[W-1] != i_b[W-1]) && (w_dif[W-1] != i_a[W-1]);
        // Saturating sub reports "clamped" in C rather than no-borrow
        if (SAT) begin
          o_c = w_dif[W];
          if (w_dif[W]) o_r = '0;
        end
      end
      3'd2: o_r = i_a & i_b;
      3'd3: o_r = i_a | i_b;
      3'd4: o_r = i_a ^ i_b;
      3'd5: o_r = i_a << w_sh;
      3'd6: o_r = i_a >> w_sh;
      default: o_r = i_a;
    endcase
  end
endmodule

module execute_vector_stage #(
  parameter int LANES    = 8,
  parameter int LANE_W   = 8,
  parameter int SCALAR_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    FlushE,
  input  logic                    VectorWrite_E,
  input  logic                    ScalarWrite_E,
  input  logic                    FlagWrite_E,
  input  logic                    ImmSrc_E,
  input  logic [2:0]              ALUControl_E,
  input  logic [2:0]              LanesControl_E,
  input  logic [SCALAR_W-1:0]     Imm_E,
  input  logic [SCALAR_W-1:0]     RnDA_E,
  input  logic [SCALAR_W-1:0]     RnDB_E,
  input  logic [LANES*LANE_W-1:0] RvDA_E,
  input  logic [2:0]              RnD_E,
  output logic                    Busy_E,
  output logic                    Done_M,
  output logic                    VectorWrite_M,
  output logic                    ScalarWrite_M,
  output logic [LANES*LANE_W-1:0] VecResult_M,
  output logic [SCALAR_W-1:0]     ScalarResult_M,
  output logic [2:0]              Dest_M,
  output logic [3:0]              Flags_M
);
`ifdef VECTOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t r_state, w_state_n;
  logic [2:0] r_cnt, w_cnt_n;
  logic [LANES-1:0][LANE_W-1:0] r_part, w_lres, w_mres;
  logic [LANES-1:0] r_pc, r_pv, w_lc, w_lv, w_mc, w_mv;
  logic [1:0] w_lg;
  logic [2:0] w_last, w_k;
  logic [LANE_W-1:0] w_opb8;
  logic [SCALAR_W-1:0] w_opb, w_sres;
  logic w_sc, w_sv;
  logic w_fin_vec, w_fin_sc, w_store, w_clr;

  // log2(lanes per cycle); the last group index is then 7 >> lg
  assign w_lg   = (LanesControl_E > 3'd3) ? 2'd3 : LanesControl_E[1:0];
  assign w_last = 3'd7 >> w_lg;
  assign w_k    = (r_state == RUN) ? r_cnt : 3'd0;
  assign w_opb  = ImmSrc_E ? Imm_E : RnDB_E;
  assign w_opb8 = w_opb[LANE_W-1:0];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    alu_lane #(.W(LANE_W), .SAT(SAT)) u_lane (
      .i_op(ALUControl_E), .i_a(RvDA_E[g*LANE_W +: LANE_W]), .i_b(w_opb8),
      .o_r(w_lres[g]), .o_c(w_lc[g]), .o_v(w_lv[g])
    );
  end

  alu_lane #(.W(SCALAR_W), .SAT(1'b0)) u_scalar (
    .i_op(ALUControl_E), .i_a(RnDA_E), .i_b(w_opb),
    .o_r(w_sres), .o_c(w_sc), .o_v(w_sv)
  );

  // Current group's lanes come from the ALUs; earlier groups from the partial register
  always_comb begin
    w_mres = r_part;
    w_mc   = r_pc;
    w_mv   = r_pv;
    for (int i = 0; i < LANES; i++) begin
      if ((3'(i) >> w_lg) == w_k) begin
        w_mres[i] = w_lres[i];
        w_mc[i]   = w_lc[i];
        w_mv[i]   = w_lv[i];
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_fin_vec = 1'b0;
    w_fin_sc  = 1'b0;
    w_store   = 1'b0;
    w_clr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!FlushE) begin
          if (VectorWrite_E) begin
            if (w_last == 3'd0) w_fin_vec = 1'b1;
            else begin
              w_store   = 1'b1;
              w_state_n = RUN;
              w_cnt_n   = 3'd1;
            end
          end else if (ScalarWrite_E) begin
            w_fin_sc = 1'b1;
          end
        end
      end
      RUN: begin
        if (FlushE) begin
          w_state_n = IDLE;
          w_cnt_n   = 3'd0;
          w_clr     = 1'b1;
        end else if (r_cnt == w_last) begin
          w_fin_vec = 1'b1;
          w_state_n = IDLE;
          w_cnt_n   = 3'd0;
        end else begin
          w_store = 1'b1;
          w_cnt_n = r_cnt + 3'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Gated by reset so the stall drops the instant reset is asserted mid-op
  assign Busy_E = ~reset & ~FlushE &
                  ((r_state == RUN) ? (r_cnt != w_last) : (VectorWrite_E && (w_last != 3'd0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_part         <= '0;
      r_pc           <= '0;
      r_pv           <= '0;
      Done_M         <= 1'b0;
      VectorWrite_M  <= 1'b0;
      ScalarWrite_M  <= 1'b0;
      VecResult_M    <= '0;
      ScalarResult_M <= '0;
      Dest_M         <= '0;
      Flags_M        <= '0;
    end else begin
      r_state       <= w_state_n;
      r_cnt         <= w_cnt_n;
      Done_M        <= w_fin_vec | w_fin_sc;
      VectorWrite_M <= w_fin_vec;
      ScalarWrite_M <= w_fin_sc;
      if (w_clr) begin
        r_part <= '0;
        r_pc   <= '0;
        r_pv   <= '0;
      end else if (w_store) begin
        r_part <= w_mres;
        r_pc   <= w_mc;
        r_pv   <= w_mv;
      end
      if (w_fin_vec) begin
        VecResult_M <= w_mres;
        Dest_M      <= RnD_E;
        if (FlagWrite_E)
          Flags_M <= {w_mres[LANES-1][LANE_W-1], ~|w_mres, |w_mc, |w_mv};
      end
      if (w_fin_sc) begin
        ScalarResult_M <= w_sres;
        Dest_M         <= RnD_E;
        if (FlagWrite_E)
          Flags_M <= {w_sres[SCALAR_W-1], ~|w_sres, w_sc, w_sv};
      end
    end
  end
endmodule

// File: tb/tb_execute_vector_stage.sv
// Bench for execute_vector_stage: directed plan items plus random ops against an arithmetic model.
module tb_execute_vector_stage;
`ifdef VECTOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, FlushE, VectorWrite_E, ScalarWrite_E, FlagWrite_E, ImmSrc_E;
  logic [2:0] ALUControl_E, LanesControl_E, RnD_E;
  logic [15:0] Imm_E, RnDA_E, RnDB_E;
  logic [63:0] RvDA_E;
  logic Busy_E, Done_M, VectorWrite_M, ScalarWrite_M;
  logic [63:0] VecResult_M;
  logic [15:0] ScalarResult_M;
  logic [2:0] Dest_M;
  logic [3:0] Flags_M;

  int checks = 0;
  int failures = 0;
  logic [63:0] m_vec;
  logic [15:0] m_sc;
  logic [2:0] m_dest;
  logic [3:0] m_flags;

  execute_vector_stage dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .VectorWrite_E(VectorWrite_E),
    .ScalarWrite_E(ScalarWrite_E), .FlagWrite_E(FlagWrite_E), .ImmSrc_E(ImmSrc_E),
    .ALUControl_E(ALUControl_E), .LanesControl_E(LanesControl_E), .Imm_E(Imm_E),
    .RnDA_E(RnDA_E), .RnDB_E(RnDB_E), .RvDA_E(RvDA_E), .RnD_E(RnD_E),
    .Busy_E(Busy_E), .Done_M(Done_M), .VectorWrite_M(VectorWrite_M),
    .ScalarWrite_M(ScalarWrite_M), .VecResult_M(VecResult_M),
    .ScalarResult_M(ScalarResult_M), .Dest_M(Dest_M), .Flags_M(Flags_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU on plain integers; signed overflow from range of the signed result
  task automatic model_alu(input int w, input int op, input int a, input int b, input bit sat,
                           output int r, output bit c, output bit v);
    int md, hf, s, sa, sb, sv;
    md = 1 << w;
    hf = md / 2;
    sa = (a >= hf) ? a - md : a;
    sb = (b >= hf) ? b - md : b;
    r = a; c = 1'b0; v = 1'b0;
    case (op)
      0: begin
        s = a + b; r = s % md; c = (s >= md);
        sv = sa + sb; v = (sv >= hf) || (sv < -hf);
        if (sat && s >= md) r = md - 1;
      end
      1: begin
        s = a - b; r = (s + md) % md; c = (a >= b);
        sv = sa - sb; v = (sv >= hf) || (sv < -hf);
        if (sat) begin c = (a < b); if (a < b) r = 0; end
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a << (b % 8)) % md;
      6: r = a >> (b % 8);
      default: r = a;
    endcase
  endtask

  task automatic set_in(input bit vw, input bit sw, input bit fw, input bit is, input logic [2:0] alu,
                        input logic [2:0] lc, input logic [2:0] dst, input logic [15:0] imm,
                        input logic [15:0] a, input logic [15:0] b, input logic [63:0] va);
    VectorWrite_E = vw; ScalarWrite_E = sw; FlagWrite_E = fw; ImmSrc_E = is;
    ALUControl_E = alu; LanesControl_E = lc; RnD_E = dst; Imm_E = imm;
    RnDA_E = a; RnDB_E = b; RvDA_E = va;
  endtask

  task automatic run_op(input string tag, input bit vw, input bit sw, input bit fw, input bit is,
                        input logic [2:0] alu, input logic [2:0] lc, input logic [2:0] dst,
                        input logic [15:0] imm, input logic [15:0] a, input logic [15:0] b,
                        input logic [63:0] va);
    int g, ob, r;
    bit c, v, cor, vor;
    logic [63:0] vec;
    ob = is ? int'(imm) : int'(b);
    g = 1;
    cor = 1'b0; vor = 1'b0;
    if (vw) begin
      g = (lc == 0) ? 8 : (lc == 1) ? 4 : (lc == 2) ? 2 : 1;
      for (int i = 0; i < 8; i++) begin
        model_alu(8, int'(alu), int'(va[8*i +: 8]), ob % 256, SAT, r, c, v);
        vec[8*i +: 8] = 8'(r);
        cor |= c; vor |= v;
      end
      m_vec = vec; m_dest = dst;
      if (fw) m_flags = {vec[63], vec == 64'd0, cor, vor};
    end else if (sw) begin
      model_alu(16, int'(alu), int'(a), ob, 1'b0, r, c, v);
      m_sc = 16'(r); m_dest = dst;
      if (fw) m_flags = {m_sc[15], m_sc == 16'd0, c, v};
    end
    set_in(vw, sw, fw, is, alu, lc, dst, imm, a, b, va);
    for (int cy = 0; cy < g; cy++) begin
      #1;
      chk({tag, "_busy"}, 64'(Busy_E), 64'(vw && (cy < g - 1)));
      if (cy > 0) chk({tag, "_early_done"}, 64'(Done_M), 64'd0);
      @(posedge clk);
    end
    #1;
    chk({tag, "_done"}, 64'(Done_M), 64'(vw | sw));
    chk({tag, "_vw"}, 64'(VectorWrite_M), 64'(vw));
    chk({tag, "_sw"}, 64'(ScalarWrite_M), 64'(sw & ~vw));
    chk({tag, "_vec"}, VecResult_M, m_vec);
    chk({tag, "_sc"}, 64'(ScalarResult_M), 64'(m_sc));
    chk({tag, "_dest"}, 64'(Dest_M), 64'(m_dest));
    chk({tag, "_flags"}, 64'(Flags_M), 64'(m_flags));
    VectorWrite_E = 1'b0; ScalarWrite_E = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_bubble_done"}, 64'(Done_M), 64'd0);
    chk({tag, "_bubble_vec"}, VecResult_M, m_vec);
  endtask

  initial begin
    m_vec = '0; m_sc = '0; m_dest = '0; m_flags = '0;
    reset = 1'b1; FlushE = 1'b0;
    set_in(0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 16'd0, 16'd0, 16'd0, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_done", 64'(Done_M), 64'd0);
    chk("rst_vec", VecResult_M, 64'd0);
    chk("rst_flags", 64'(Flags_M), 64'd0);
    chk("rst_busy", 64'(Busy_E), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    run_op("sc_add", 0, 1, 1, 0, 3'd0, 3'd0, 3'd2, 16'd0, 16'h7FFF, 16'h0001, 64'd0);
    chk("sc_add_const", 64'(ScalarResult_M), 64'h8000);
    chk("sc_add_nzcv", 64'(Flags_M), 64'b1001);

    run_op("v2_add", 1, 0, 1, 1, 3'd0, 3'd1, 3'd5, 16'h0010, 16'd0, 16'd0, 64'h0102030405060708);
    chk("v2_add_const", VecResult_M, 64'h1112131415161718);

    run_op("wrap", 1, 0, 1, 0, 3'd0, 3'd3, 3'd1, 16'd0, 16'd0, 16'h0020, {8{8'hF0}});
    chk("wrap_const", VecResult_M, SAT ? 64'hFFFFFFFFFFFFFFFF : 64'h1010101010101010);
    chk("wrap_c", 64'(Flags_M[1]), 64'd1);

    run_op("both", 1, 1, 0, 1, 3'd3, 3'd7, 3'd6, 16'h00A5, 16'h1234, 16'd0, 64'h00FF00FF12345678);

    // Flush on the third cycle of a 1-lane/cycle op
    set_in(1, 0, 1, 1, 3'd0, 3'd0, 3'd4, 16'h0001, 16'd0, 16'd0, 64'h8080808080808080);
    @(posedge clk); @(posedge clk); #1;
    FlushE = 1'b1; #1;
    chk("flush_busy", 64'(Busy_E), 64'd0);
    @(posedge clk); #1;
    FlushE = 1'b0; VectorWrite_E = 1'b0;
    chk("flush_done", 64'(Done_M), 64'd0);
    chk("flush_vw", 64'(VectorWrite_M), 64'd0);
    chk("flush_flags", 64'(Flags_M), 64'(m_flags));
    @(posedge clk); #1;
    chk("flush_after_done", 64'(Done_M), 64'd0);
    run_op("post_flush", 0, 1, 1, 0, 3'd1, 3'd0, 3'd3, 16'd0, 16'h0005, 16'h0007, 64'd0);

    for (int n = 0; n < 40; n++) begin
      run_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 16'($urandom()), 16'($urandom()), 16'($urandom()),
             {$urandom(), $urandom()});
    end

    // Async reset between edges while a 2-lane/cycle op is running
    set_in(1, 0, 1, 0, 3'd4, 3'd1, 3'd7, 16'd0, 16'd0, 16'h00FF, 64'h0123456789ABCDEF);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1; #1;
    chk("arst_busy", 64'(Busy_E), 64'd0);
    chk("arst_done", 64'(Done_M), 64'd0);
    chk("arst_vec", VecResult_M, 64'd0);
    chk("arst_flags", 64'(Flags_M), 64'd0);
    m_vec = '0; m_sc = '0; m_dest = '0; m_flags = '0;
    VectorWrite_E = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    run_op("after_rst", 1, 0, 1, 0, 3'd1, 3'd1, 3'd2, 16'd0, 16'd0, 16'h0011, 64'h0010203040506070);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
